// File: rtl/mul_pkg.sv
// Shared types and sizing for the shift-add multiplier controller.
package mul_pkg;

   localparam int unsigned MUL_BITS   = 32;
   localparam int unsigned MUL_ITER_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } mul_state_t;

endpackage

// File: rtl/cla_adder_core.sv
// BITS-wide adder with 4-bit carry-lookahead groups; BITS must be a multiple of 4.
module cla_adder_core #(
   parameter int unsigned BITS = 32
) (
   input  logic [BITS-1:0] a,
   input  logic [BITS-1:0] b,
   input  logic            cin,
   output logic [BITS-1:0] sum,
   output logic            cout
);

   localparam int unsigned GRP = 4;

   logic [BITS-1:0] g;
   logic [BITS-1:0] p;

   assign g = a & b;
   assign p = a ^ b;

   // Bit carries ripple inside a group; the group carry-out is formed from
   // the group generate/propagate terms so it skips the in-group chain.
   always_comb begin
      logic carry;
      logic c;
      logic gg;
      logic gp;
      sum   = '0;
      carry = cin;
      c     = cin;
      gg    = 1'b0;
      gp    = 1'b1;
      for (int unsigned i = 0; i < BITS; i++) begin
         sum[i] = p[i] ^ c;
         c      = g[i] | (p[i] & c);
         gg     = g[i] | (p[i] & gg);
         gp     = gp & p[i];
         if ((i % GRP) == (GRP - 1)) begin
            carry = gg | (gp & carry);
            c     = carry;
            gg    = 1'b0;
            gp    = 1'b1;
         end
      end
      cout = carry;
   end

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Multi-cycle BITSxBITS shift-add multiplier sharing one adder across iterations.
// Define SIGNED_MUL_EN to add the is_signed port, magnitude load and FIX negate state.
module shift_add_mul_ctrl
   import mul_pkg::*;
#(
   parameter int unsigned BITS   = MUL_BITS,
   parameter int unsigned ITER_W = MUL_ITER_W
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            start,
`ifdef SIGNED_MUL_EN
   input  logic            is_signed,
`endif
   input  logic [BITS-1:0] multiplicand,
   input  logic [BITS-1:0] multiplier,
   output logic            busy,
   output logic            done,
   output logic [BITS-1:0] product_hi,
   output logic [BITS-1:0] product_lo
);

   mul_state_t        state_q, state_d;
   logic [ITER_W-1:0] cnt_q, cnt_d;
   logic [BITS-1:0]   mcand_q, mcand_d;
   logic [BITS-1:0]   hi_q, hi_d;
   logic [BITS-1:0]   lo_q, lo_d;
   logic [BITS-1:0]   a_load, b_load;
   logic [BITS-1:0]   addend, sum;
   logic              cout;
   logic              last_iter;
`ifdef SIGNED_MUL_EN
   logic              neg_q, neg_d;
   logic              a_neg, b_neg;
`endif

   assign addend    = lo_q[0] ? mcand_q : '0;
   assign last_iter = (cnt_q == ITER_W'(BITS - 1));

   cla_adder_core #(.BITS(BITS)) u_adder (
      .a    (hi_q),
      .b    (addend),
      .cin  (1'b0),
      .sum  (sum),
      .cout (cout)
   );

   always_comb begin
`ifdef SIGNED_MUL_EN
      a_neg  = is_signed & multiplicand[BITS-1];
      b_neg  = is_signed & multiplier[BITS-1];
      a_load = a_neg ? (~multiplicand + BITS'(1)) : multiplicand;
      b_load = b_neg ? (~multiplier + BITS'(1)) : multiplier;
`else
      a_load = multiplicand;
      b_load = multiplier;
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mcand_d = mcand_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
`ifdef SIGNED_MUL_EN
      neg_d   = neg_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d = a_load;
               lo_d    = b_load;
               hi_d    = '0;
               cnt_d   = '0;
`ifdef SIGNED_MUL_EN
               neg_d   = a_neg ^ b_neg;
`endif
               state_d = ITER;
            end
         end
         ITER: begin
            // Carry-out becomes the new HI MSB, so all-ones operands cannot overflow.
            {hi_d, lo_d} = {cout, sum, lo_q[BITS-1:1]};
            cnt_d        = cnt_q + ITER_W'(1);
            if (last_iter) begin
`ifdef SIGNED_MUL_EN
               state_d = neg_q ? FIX : DONE;
`else
               state_d = DONE;
`endif
            end
         end
`ifdef SIGNED_MUL_EN
         FIX: begin
            // Dedicated incrementer; the shared adder stays on the iteration path only.
            {hi_d, lo_d} = ~{hi_q, lo_q} + (2 * BITS)'(1);
            state_d      = DONE;
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
`ifdef SIGNED_MUL_EN
         neg_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
`ifdef SIGNED_MUL_EN
         neg_q   <= neg_d;
`endif
      end
   end

   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign product_hi = hi_q;
   assign product_lo = lo_q;

endmodule
